// File: rtl/pat_mem_arbiter_pkg.sv
// Shared types and constants for the pattern memory arbiter.
package pat_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_STALL = 2'd1,
    H_ABORT = 2'd2
  } h_state_t;

  localparam logic OWNER_F = 1'b0;
  localparam logic OWNER_H = 1'b1;

  localparam logic [31:0] START_WORD = 32'hFDFDFDFD;

  typedef struct packed {
    logic valid;
    logic owner;
    logic abort;
  } rtag_t;

  // A command carrying both read and write is a write, so it never reads.
  function automatic logic is_read(input logic rd, input logic wr);
    return rd & ~wr;
  endfunction

endpackage

// File: rtl/pat_mem_rtag_pipe.sv
// Read tag pipe: delays {valid, owner, abort} by the memory read latency so
// returning data can be steered to the port that issued the read.
module pat_mem_rtag_pipe
  import pat_mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  rtag_t tag_in,
  output rtag_t tag_out
);

  rtag_t stage [RD_LAT];

  // Shift tags one stage per cycle; reset drops every tag in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/pat_mem_arbiter.sv
// Arbiter for the single-port pattern memory: the fetch engine (F) always
// wins, the host path (H) waits via waitrequest and is aborted after a
// bounded stall. Read data is returned through a latency-matched tag pipe.
module pat_mem_arbiter
  import pat_mem_arbiter_pkg::*;
#(
  parameter int          AW        = 13,
  parameter int          DW        = 256,
  parameter int          RD_LAT    = 1,
  parameter int          TIMEOUT   = 4096,
  parameter int unsigned ABORT_VAL = 32'hDEAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_read,
  input  logic              f_write,
  input  logic [AW-1:0]     f_addr,
  input  logic [DW-1:0]     f_wdata,
  input  logic [DW/8-1:0]   f_be,
  output logic [DW-1:0]     f_rdata,
  output logic              f_rvalid,
  input  logic              f_lock,
  input  logic              h_read,
  input  logic              h_write,
  input  logic [AW-1:0]     h_addr,
  input  logic [DW-1:0]     h_wdata,
  input  logic [DW/8-1:0]   h_be,
  output logic              h_waitreq,
  output logic [DW-1:0]     h_rdata,
  output logic              h_rvalid,
  output logic              h_timeout,
  input  logic              h_err_clr,
  output logic              mem_cs,
  output logic              mem_clken,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [DW/8-1:0]   mem_be,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int            CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT - 1);

  h_state_t      h_state;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_next;
  logic          abort_rd;

  logic  f_req, f_rd;
  logic  h_req, h_rd;
  logic  h_legal, h_grant, h_abort;
  logic  h_data_v, abort_v;
  rtag_t tag_in, tag_out;

  // Request decode and grant decision; reset suppresses every grant.
  always_comb begin
    f_req      = f_read | f_write;
    f_rd       = is_read(f_read, f_write);
    h_req      = h_read | h_write;
    h_rd       = is_read(h_read, h_write);
    h_legal    = rst_n & h_req & ~f_req & ~(h_write & f_lock);
    h_grant    = h_legal & (h_state != H_ABORT);
    h_abort    = rst_n & (h_state == H_ABORT);
    stall_next = (h_state == H_STALL) ? stall_cnt + CW'(1) : CW'(1);
  end

  // Command mux: F has priority, then a granted H access, else idle.
  always_comb begin
    mem_cs    = rst_n;
    mem_clken = 1'b1;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    h_waitreq = ~(h_grant | h_abort);
    if (rst_n && f_req) begin
      mem_rd    = f_rd;
      mem_wr    = f_write;
      mem_addr  = f_addr;
      mem_be    = f_be;
      mem_wdata = f_wdata;
    end else if (h_grant) begin
      mem_rd    = h_rd;
      mem_wr    = h_write;
      mem_addr  = h_addr;
      mem_be    = h_be;
      mem_wdata = h_wdata;
    end
  end

  // Build the tag for this cycle; an abort rides alongside any F read.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = (rst_n & f_req & f_rd) | (h_grant & h_rd);
    tag_in.owner = f_req ? OWNER_F : OWNER_H;
    tag_in.abort = h_abort & abort_rd;
  end

  pat_mem_rtag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rtag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Steer returning data to its owner; aborted H reads return ABORT_VAL.
  always_comb begin
    f_rvalid = rst_n & tag_out.valid & (tag_out.owner == OWNER_F);
    h_data_v = rst_n & tag_out.valid & (tag_out.owner == OWNER_H);
    abort_v  = rst_n & tag_out.abort;
    h_rvalid = h_data_v | abort_v;
    f_rdata  = f_rvalid ? mem_rdata : '0;
    if (abort_v) begin
      h_rdata = DW'(ABORT_VAL);
    end else if (h_data_v) begin
      h_rdata = mem_rdata;
    end else begin
      h_rdata = '0;
    end
  end

  // H FSM, stall counter and sticky timeout flag (set beats clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_state   <= H_IDLE;
      stall_cnt <= '0;
      abort_rd  <= 1'b0;
      h_timeout <= 1'b0;
    end else begin
      if (h_abort) begin
        h_timeout <= 1'b1;
      end else if (h_err_clr) begin
        h_timeout <= 1'b0;
      end
      case (h_state)
        H_IDLE, H_STALL: begin
          if (!h_req || h_legal) begin
            h_state   <= H_IDLE;
            stall_cnt <= '0;
          end else if (stall_next >= STALL_LIMIT) begin
            h_state   <= H_ABORT;
            stall_cnt <= '0;
            abort_rd  <= h_rd;
          end else begin
            h_state   <= H_STALL;
            stall_cnt <= stall_next;
          end
        end
        H_ABORT: begin
          h_state  <= H_IDLE;
          abort_rd <= 1'b0;
        end
        default: begin
          h_state   <= H_IDLE;
          stall_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pat_mem_arbiter.sv
// Self-checking bench for pat_mem_arbiter with a behavioural memory and a
// read-return scoreboard.
module tb_pat_mem_arbiter;
  import pat_mem_arbiter_pkg::*;

  localparam int AW      = 13;
  localparam int DW      = 256;
  localparam int BW      = DW / 8;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 16;
  localparam logic [DW-1:0] ABORT_DATA = DW'(32'hDEAD);

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } sb_entry_t;

  logic            clk, rst_n;
  logic            f_read, f_write, f_lock;
  logic [AW-1:0]   f_addr;
  logic [DW-1:0]   f_wdata;
  logic [BW-1:0]   f_be;
  logic [DW-1:0]   f_rdata;
  logic            f_rvalid;
  logic            h_read, h_write, h_err_clr;
  logic [AW-1:0]   h_addr;
  logic [DW-1:0]   h_wdata;
  logic [BW-1:0]   h_be;
  logic            h_waitreq, h_rvalid, h_timeout;
  logic [DW-1:0]   h_rdata;
  logic            mem_cs, mem_clken, mem_rd, mem_wr;
  logic [AW-1:0]   mem_addr;
  logic [BW-1:0]   mem_be;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  sb_entry_t f_q[$];
  sb_entry_t h_q[$];

  logic [DW-1:0] ref_mem   [64];
  logic [DW-1:0] mem_array [64];
  logic [DW-1:0] rd_pipe   [RD_LAT];
  logic          mon_ef, mon_eh;

  pat_mem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT), .ABORT_VAL(32'hDEAD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .f_read(f_read), .f_write(f_write), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_be(f_be), .f_rdata(f_rdata), .f_rvalid(f_rvalid), .f_lock(f_lock),
    .h_read(h_read), .h_write(h_write), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_be(h_be), .h_waitreq(h_waitreq), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .h_timeout(h_timeout), .h_err_clr(h_err_clr),
    .mem_cs(mem_cs), .mem_clken(mem_clken), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] pat(input int a);
    logic [DW-1:0] v;
    for (int k = 0; k < 8; k++) begin
      v[k*32 +: 32] = 32'h1000_0000 + 32'(a) * 32'h0000_0101 + 32'(k);
    end
    return v;
  endfunction

  // Behavioural single-port memory with RD_LAT read latency.
  always @(posedge clk) begin
    if (mem_cs && mem_wr) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_be[b]) mem_array[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    rd_pipe[0] <= (mem_cs && mem_rd) ? mem_array[mem_addr[5:0]] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic checkOutput(input string tag, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of F/H commands; F reads are always served, so queue them now.
  task automatic applyStimulus(input logic fr, input logic [AW-1:0] fa,
                               input logic hr, input logic hw,
                               input logic [AW-1:0] ha, input logic [DW-1:0] hwd);
    f_read  = fr;
    f_write = 1'b0;
    f_addr  = fa;
    h_read  = hr;
    h_write = hw;
    h_addr  = ha;
    h_wdata = hwd;
    if (fr) f_q.push_back('{cyc + RD_LAT, ref_mem[fa[5:0]]});
  endtask

  task automatic pushH(input logic [DW-1:0] d);
    h_q.push_back('{cyc + RD_LAT, d});
  endtask

  // Scoreboard: every cycle, rvalid must match the queue head's due cycle.
  always @(negedge clk) begin
    mon_ef = (f_q.size() > 0) && (f_q[0].cyc == cyc);
    mon_eh = (h_q.size() > 0) && (h_q[0].cyc == cyc);
    checkOutput("f_rvalid", DW'(f_rvalid), DW'(mon_ef));
    checkOutput("h_rvalid", DW'(h_rvalid), DW'(mon_eh));
    if (mon_ef) begin
      if (f_rvalid) checkOutput("f_rdata", f_rdata, f_q[0].data);
      void'(f_q.pop_front());
    end
    if (mon_eh) begin
      if (h_rvalid) checkOutput("h_rdata", h_rdata, h_q[0].data);
      void'(h_q.pop_front());
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] w9;
    for (int i = 0; i < 64; i++) begin
      mem_array[i] <= pat(i);
      ref_mem[i] = pat(i);
    end
    rst_n = 1'b0; f_lock = 1'b0; h_err_clr = 1'b0;
    f_wdata = '0; f_be = '1; h_be = '1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();

    @(negedge clk);
    checkOutput("rst_waitreq", DW'(h_waitreq), DW'(1));
    checkOutput("rst_clken", DW'(mem_clken), DW'(1));
    checkOutput("rst_cs", DW'(mem_cs), DW'(0));
    checkOutput("rst_timeout", DW'(h_timeout), DW'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_cs", DW'(mem_cs), DW'(1));
    checkOutput("idle_waitreq", DW'(h_waitreq), DW'(1));

    // Idle H read, granted in the same cycle
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 13'd5, '0);
    pushH(ref_mem[5]);
    @(negedge clk);
    checkOutput("t1_waitreq", DW'(h_waitreq), DW'(0));
    checkOutput("t1_mem_rd", DW'(mem_rd), DW'(1));
    checkOutput("t1_mem_addr", DW'(mem_addr), DW'(5));
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();

    // F reads for 3 cycles stall an H write to addr 9
    w9 = {8{32'hA5A5_0009}};
    for (int k = 0; k < 3; k++) begin
      tick();
      applyStimulus(1'b1, AW'(k + 1), 1'b0, 1'b1, 13'd9, w9);
      @(negedge clk);
      checkOutput("t2_stall", DW'(h_waitreq), DW'(1));
      checkOutput("t2_f_addr", DW'(mem_addr), DW'(k + 1));
    end
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 13'd9, w9);
    ref_mem[9] = w9;
    @(negedge clk);
    checkOutput("t2_grant", DW'(h_waitreq), DW'(0));
    checkOutput("t2_mem_wr", DW'(mem_wr), DW'(1));
    checkOutput("t2_mem_addr", DW'(mem_addr), DW'(9));
    checkOutput("t2_mem_wdata", mem_wdata, w9);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 13'd9, '0);
    pushH(ref_mem[9]);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Locked H write of the start word times out after TIMEOUT-1 stalls
    tick();
    f_lock = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 13'd0, DW'(START_WORD));
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      @(negedge clk);
      checkOutput("t3_stall", DW'(h_waitreq), DW'(1));
      checkOutput("t3_no_wr", DW'(mem_wr), DW'(0));
      tick();
    end
    @(negedge clk);
    checkOutput("t3_abort_wait", DW'(h_waitreq), DW'(0));
    checkOutput("t3_abort_no_wr", DW'(mem_wr), DW'(0));
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("t3_timeout_set", DW'(h_timeout), DW'(1));
    tick();
    h_err_clr = 1'b1;
    tick();
    h_err_clr = 1'b0;
    @(negedge clk);
    checkOutput("t3_timeout_clr", DW'(h_timeout), DW'(0));

    // Lock does not block H reads; addr 0 must be unwritten
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 13'd0, '0);
    pushH(ref_mem[0]);
    @(negedge clk);
    checkOutput("t4_grant", DW'(h_waitreq), DW'(0));
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    f_lock = 1'b0;
    @(negedge clk);
    checkOutput("t4_timeout", DW'(h_timeout), DW'(0));

    // H read starved by F until abort; clear and abort collide
    for (int k = 0; k < TIMEOUT; k++) begin
      tick();
      applyStimulus(1'b1, AW'(30 + (k % 4)), 1'b1, 1'b0, 13'd20, '0);
      h_err_clr = (k == TIMEOUT - 1);
      if (k == TIMEOUT - 1) pushH(ABORT_DATA);
      @(negedge clk);
      checkOutput("t5_waitreq", DW'(h_waitreq), DW'(k == TIMEOUT - 1 ? 0 : 1));
    end
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    h_err_clr = 1'b0;
    @(negedge clk);
    checkOutput("t5_set_wins", DW'(h_timeout), DW'(1));
    tick();
    h_err_clr = 1'b1;
    tick();
    h_err_clr = 1'b0;

    // F read then H read on adjacent cycles
    tick();
    applyStimulus(1'b1, 13'd10, 1'b0, 1'b0, '0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 13'd11, '0);
    pushH(ref_mem[11]);
    @(negedge clk);
    checkOutput("t6_grant", DW'(h_waitreq), DW'(0));
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();

    // Reset while an F read is in flight: its data must never appear
    tick();
    applyStimulus(1'b1, 13'd13, 1'b0, 1'b0, '0, '0);
    void'(f_q.pop_back());
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t7_rst_cs", DW'(mem_cs), DW'(0));
    checkOutput("t7_rst_waitreq", DW'(h_waitreq), DW'(1));
    checkOutput("t7_rst_timeout", DW'(h_timeout), DW'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t7_after_cs", DW'(mem_cs), DW'(1));
    repeat (3) tick();

    @(negedge clk);
    checkOutput("f_queue_empty", DW'(f_q.size()), DW'(0));
    checkOutput("h_queue_empty", DW'(h_q.size()), DW'(0));
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
